// File: rtl/mem_pkg.sv
// Shared state encoding and defaults for the memory responder core.
package mem_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int WORD_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: synchronous write, registered read.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WORD_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [2**DEPTH_LOG2];

   // NOTE: storage and its read register carry no reset so they map onto block RAM;
   // the core masks rdata until the first completed read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with optional read wait states.
// Define MEM_RANGE_CHECK_EN to reject addresses with bits set above DEPTH_LOG2-1.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH_LOG2 = 10,
   parameter int READ_WAIT  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   output logic [WORD_WIDTH-1:0] mem_rdata,
   output logic                  mem_ready,
   output logic                  mem_err
);

`ifdef MEM_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   localparam logic [3:0] WAIT_LOAD = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

   state_t                state, state_d;
   logic [3:0]            wait_cnt, wait_cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  oor_q;
   logic                  err_q, err_d;
   logic                  zero_q, zero_d;
   logic                  lat_en;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req_oor;
   logic                  arr_we, arr_re;
   logic [DEPTH_LOG2-1:0] arr_raddr;
   logic [WORD_WIDTH-1:0] arr_rdata;

   assign req_idx = mem_addr[DEPTH_LOG2-1:0];
   assign req_oor = RANGE_CHECK && ((mem_addr >> DEPTH_LOG2) != '0);

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d    = state;
      wait_cnt_d = wait_cnt;
      err_d      = 1'b0;
      zero_d     = zero_q;
      lat_en     = 1'b0;
      arr_we     = 1'b0;
      arr_re     = 1'b0;
      arr_raddr  = idx_q;

      case (state)
         IDLE: begin
            if (mem_wr) begin
               // A simultaneous read is ignored but flagged.
               arr_we  = !req_oor && !reset;
               err_d   = mem_rd || req_oor;
               state_d = RESP;
            end else if (mem_rd) begin
               lat_en = 1'b1;
               if (READ_WAIT == 0) begin
                  arr_re    = 1'b1;
                  arr_raddr = req_idx;
                  zero_d    = req_oor;
                  err_d     = req_oor;
                  state_d   = RESP;
               end else begin
                  wait_cnt_d = WAIT_LOAD;
                  state_d    = WAIT;
               end
            end
         end
         WAIT: begin
            err_d = mem_rd || mem_wr;
            if (wait_cnt == 4'd0) begin
               arr_re  = 1'b1;
               zero_d  = oor_q;
               err_d   = err_d || oor_q;
               state_d = RESP;
            end else begin
               wait_cnt_d = wait_cnt - 4'd1;
            end
         end
         RESP: begin
            err_d   = mem_rd || mem_wr;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         idx_q    <= '0;
         oor_q    <= 1'b0;
         err_q    <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         state    <= state_d;
         wait_cnt <= wait_cnt_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
         if (lat_en) begin
            idx_q <= req_idx;
            oor_q <= req_oor;
         end
      end
   end

   mem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .waddr(req_idx),
      .wdata(mem_wdata),
      .re   (arr_re),
      .raddr(arr_raddr),
      .rdata(arr_rdata)
   );

   // zero_q covers both the post-reset value and out-of-range reads.
   assign mem_rdata = zero_q ? '0 : arr_rdata;
   assign mem_ready = (state == RESP);
   assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder at READ_WAIT = 0, 3 and 2.
module tb_mem_responder;

   localparam int DL = 4;
   localparam int NW = 1 << DL;

`ifdef MEM_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   typedef struct {
      bit          ready;
      bit          err;
      bit          chk_rdata;
      logic [31:0] rdata;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int RW = (g == 0) ? 0 : ((g == 1) ? 3 : 2);

      logic        reset;
      logic [31:0] mem_addr, mem_wdata, mem_rdata;
      logic        mem_rd, mem_wr, mem_ready, mem_err;
      bit          done = 1'b0;

      mem_responder #(
         .ADDR_WIDTH(32),
         .DEPTH_LOG2(DL),
         .READ_WAIT (RW)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .mem_addr (mem_addr),
         .mem_wdata(mem_wdata),
         .mem_rd   (mem_rd),
         .mem_wr   (mem_wr),
         .mem_rdata(mem_rdata),
         .mem_ready(mem_ready),
         .mem_err  (mem_err)
      );

      // Reference model: expected responses keyed by the negedge index they appear at.
      resp_t       exp_q [int];
      logic [31:0] mem_m [NW];
      logic [31:0] last_rdata;
      int          free_idx;

      function automatic bit out_of_range(input logic [31:0] a);
         return RANGE_CHECK && ((a >> DL) != 32'd0);
      endfunction

      task automatic add_evt(input int k, input bit rdy, input bit er, input logic [31:0] rd);
         resp_t e;
         e = '{default: '0};
         if (exp_q.exists(k)) e = exp_q[k];
         e.err = e.err | er;
         if (rdy) begin
            e.ready     = 1'b1;
            e.chk_rdata = 1'b1;
            e.rdata     = rd;
         end
         exp_q[k] = e;
      endtask

      // One call drives one cycle of inputs; the model predicts the response timing.
      task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
         int          k;
         bit          oor;
         logic [31:0] v;
         logic [DL-1:0] idx;
         @(negedge clk);
         k = cyc;
         mem_rd    = rd;
         mem_wr    = wr;
         mem_addr  = a;
         mem_wdata = d;
         if (!(rd || wr)) return;
         oor = out_of_range(a);
         idx = a[DL-1:0];
         if (k < free_idx) begin
            add_evt(k + 1, 1'b0, 1'b1, 32'h0);
         end else if (wr) begin
            if (!oor) mem_m[idx] = d;
            add_evt(k + 1, 1'b1, rd || oor, last_rdata);
            free_idx = k + 2;
         end else begin
            v = oor ? 32'h0 : mem_m[idx];
            last_rdata = v;
            add_evt(k + RW + 1, 1'b1, oor, v);
            free_idx = k + RW + 2;
         end
      endtask

      task automatic idle(input int n);
         for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
      endtask

      task automatic pulse_reset();
         int kill [$];
         @(negedge clk);
         reset  = 1'b1;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         foreach (exp_q[key]) if (key >= cyc) kill.push_back(key);
         foreach (kill[i]) exp_q.delete(kill[i]);
         last_rdata = 32'h0;
         free_idx   = 0;
         repeat (2) @(negedge clk);
         check($sformatf("cfg%0d rdata after reset", g), mem_rdata, 32'h0);
         reset = 1'b0;
      endtask

      always @(negedge clk) begin
         resp_t e;
         int    k;
         k = cyc;
         if (mem_ready || mem_err || exp_q.exists(k)) begin
            e = '{default: '0};
            if (exp_q.exists(k)) begin
               e = exp_q[k];
               exp_q.delete(k);
            end
            check($sformatf("cfg%0d ready", g), {31'h0, mem_ready}, {31'h0, e.ready});
            check($sformatf("cfg%0d err", g), {31'h0, mem_err}, {31'h0, e.err});
            if (e.chk_rdata) check($sformatf("cfg%0d rdata", g), mem_rdata, e.rdata);
         end
      end

      initial begin
         int          r;
         logic [31:0] a;
         reset      = 1'b1;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         mem_addr   = 32'h0;
         mem_wdata  = 32'h0;
         last_rdata = 32'h0;
         free_idx   = 0;
         repeat (2) @(negedge clk);
         check($sformatf("cfg%0d reset ready", g), {31'h0, mem_ready}, 32'h0);
         check($sformatf("cfg%0d reset err", g), {31'h0, mem_err}, 32'h0);
         check($sformatf("cfg%0d reset rdata", g), mem_rdata, 32'h0);
         reset = 1'b0;

         for (int i = 0; i < NW; i++) begin
            drive(1'b0, 1'b1, 32'(i), $urandom());
            idle(1);
         end

         drive(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
         idle(1);
         drive(1'b1, 1'b0, 32'd5, 32'h0);
         idle(RW + 1);

         if (g == 0) begin
            drive(1'b1, 1'b1, 32'd7, 32'h12345678);
            idle(1);
            drive(1'b1, 1'b0, 32'd7, 32'h0);
            idle(1);
            drive(1'b0, 1'b1, 32'h13, 32'hA5A5A5A5);
            idle(1);
            drive(1'b1, 1'b0, 32'd3, 32'h0);
            drive(1'b1, 1'b0, 32'd5, 32'h0);
            idle(2);
         end else if (g == 1) begin
            drive(1'b1, 1'b0, 32'd9, 32'h0);
            pulse_reset();
            drive(1'b1, 1'b0, 32'd5, 32'h0);
            idle(RW + 1);
         end else begin
            drive(1'b1, 1'b0, 32'd9, 32'h0);
            drive(1'b1, 1'b0, 32'd2, 32'h0);
            idle(RW + 2);
         end

         for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) a = $urandom();
            else a = 32'($urandom_range(0, 31));
            if (r < 3) drive(1'b1, 1'b0, a, 32'h0);
            else if (r < 6) drive(1'b0, 1'b1, a, $urandom());
            else if (r == 6) drive(1'b1, 1'b1, a, $urandom());
            else idle(1);
         end
         idle(RW + 4);
         check($sformatf("cfg%0d pending responses", g), 32'(exp_q.size()), 32'h0);
         done = 1'b1;
      end
   end

   initial begin
      int budget;
      budget = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && budget < 20000) begin
         @(posedge clk);
         budget++;
      end
      if (budget >= 20000) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: waited %0d cycles, required all configurations done", budget);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
